// File: rtl/srv_addr_hit_v3_if.sv
// Address-channel bundle for srv_addr_hit_v3: upstream valid/ready address in,
// downstream registered decode result out.
interface srv_addr_hit_v3_if #(
  parameter int AW         = 32,
  parameter int MAX_REGION = 2,
  parameter int IW         = (MAX_REGION > 1) ? $clog2(MAX_REGION) : 1
);
  logic                  us_vld;
  logic                  us_rdy;
  logic [AW-1:0]         us_addr;
  logic                  ds_vld;
  logic                  ds_rdy;
  logic [AW-1:0]         ds_addr;
  logic [MAX_REGION-1:0] ds_hit;
  logic [IW-1:0]         ds_idx;
  logic                  ds_miss;

  modport master (
    output us_vld, us_addr, ds_rdy,
    input  us_rdy, ds_vld, ds_addr, ds_hit, ds_idx, ds_miss
  );

  modport slave (
    input  us_vld, us_addr, ds_rdy,
    output us_rdy, ds_vld, ds_addr, ds_hit, ds_idx, ds_miss
  );
endinterface

// File: rtl/srv_addr_hit_v3.sv
// Registered, runtime-programmable region decoder with a lockable config port.
// Optional overlap reporting (ds_multi, multi_cnt) is enabled by SRV_ADDR_HIT_MULTI_ERR_EN.
module srv_addr_hit_v3 #(
  parameter int MAX_REGION = 2,
  parameter int AW         = 32,
  parameter int GRAN       = 12,
  parameter logic [AW-1:0] REGION [MAX_REGION][2] =
    '{'{32'h5000_0000, 32'h5FFF_FFFF}, '{32'h6000_0000, 32'h6FFF_FFFF}},
  parameter bit REGION_VIS [MAX_REGION] = '{1'b1, 1'b1},
  localparam int IW = (MAX_REGION > 1) ? $clog2(MAX_REGION) : 1
) (
  input  logic            clk,
  input  logic            rst,
  srv_addr_hit_v3_if.slave bus,
  input  logic            cfg_we,
  input  logic [IW-1:0]   cfg_idx,
  input  logic [1:0]      cfg_sel,
  input  logic [AW-1:0]   cfg_wdata,
  input  logic            cfg_lock,
  output logic            cfg_err
`ifdef SRV_ADDR_HIT_MULTI_ERR_EN
  ,
  output logic            ds_multi,
  output logic [7:0]      multi_cnt
`endif
);

  localparam int HW = AW - GRAN;

  logic [HW-1:0]         base_q  [MAX_REGION];
  logic [HW-1:0]         limit_q [MAX_REGION];
  logic [MAX_REGION-1:0] vis_q;
  logic                  locked_q;
  logic                  err_q;

  logic [HW-1:0]         addr_hi;
  logic [MAX_REGION-1:0] match;
  logic [MAX_REGION-1:0] hit_d;
  logic [IW-1:0]         idx_d;
  logic                  found;

  logic                  ds_vld_q;
  logic [AW-1:0]         ds_addr_q;
  logic [MAX_REGION-1:0] ds_hit_q;
  logic [IW-1:0]         ds_idx_q;
  logic                  ds_miss_q;

  logic                  us_rdy;
  logic                  fire;
  logic                  cfg_idx_ok;
  logic                  cfg_ok;
  logic                  unused_cfg;

  assign addr_hi    = bus.us_addr[AW-1:GRAN];
  assign us_rdy     = !ds_vld_q || bus.ds_rdy;
  assign fire       = bus.us_vld && us_rdy;
  assign cfg_idx_ok = int'(cfg_idx) < MAX_REGION;
  assign cfg_ok     = cfg_we && !locked_q && cfg_idx_ok && (cfg_sel != 2'd3);
  assign unused_cfg = ^cfg_wdata;

  // Range compare on granule numbers; an inverted range (base > limit) can never match.
  always_comb begin
    match = '0;
    for (int i = 0; i < MAX_REGION; i++) begin
      match[i] = vis_q[i] && (addr_hi >= base_q[i]) && (addr_hi <= limit_q[i]);
    end
  end

  always_comb begin
    hit_d = '0;
    idx_d = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REGION; i++) begin
      if (match[i] && !found) begin
        hit_d[i] = 1'b1;
        idx_d    = IW'(i);
        found    = 1'b1;
      end
    end
  end

  // Single output register; results only change on a handshake, so a stalled
  // result is untouched by table writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_vld_q  <= 1'b0;
      ds_addr_q <= '0;
      ds_hit_q  <= '0;
      ds_idx_q  <= '0;
      ds_miss_q <= 1'b0;
    end else if (fire) begin
      ds_vld_q  <= 1'b1;
      ds_addr_q <= bus.us_addr;
      ds_hit_q  <= hit_d;
      ds_idx_q  <= idx_d;
      ds_miss_q <= !found;
    end else if (bus.ds_rdy) begin
      ds_vld_q  <= 1'b0;
    end
  end

  // Table, lock and error state; a write alongside cfg_lock still lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_REGION; i++) begin
        base_q[i]  <= REGION[i][0][AW-1:GRAN];
        limit_q[i] <= REGION[i][1][AW-1:GRAN];
        vis_q[i]   <= REGION_VIS[i];
      end
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_REGION; i++) begin
        if (cfg_ok && (int'(cfg_idx) == i)) begin
          case (cfg_sel)
            2'd0:    base_q[i]  <= cfg_wdata[AW-1:GRAN];
            2'd1:    limit_q[i] <= cfg_wdata[AW-1:GRAN];
            2'd2:    vis_q[i]   <= cfg_wdata[0];
            default: ;
          endcase
        end
      end
      if (cfg_lock)
        locked_q <= 1'b1;
      if (cfg_we && !cfg_ok)
        err_q <= 1'b1;
    end
  end

`ifdef SRV_ADDR_HIT_MULTI_ERR_EN
  logic       multi_d;
  logic       ds_multi_q;
  logic [7:0] multi_cnt_q;

  assign multi_d = |(match & (match - MAX_REGION'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_multi_q  <= 1'b0;
      multi_cnt_q <= '0;
    end else if (fire) begin
      ds_multi_q <= multi_d;
      if (multi_d && (multi_cnt_q != 8'hFF))
        multi_cnt_q <= multi_cnt_q + 8'd1;
    end
  end

  assign ds_multi  = ds_multi_q;
  assign multi_cnt = multi_cnt_q;
`endif

  assign bus.us_rdy  = us_rdy;
  assign bus.ds_vld  = ds_vld_q;
  assign bus.ds_addr = ds_addr_q;
  assign bus.ds_hit  = ds_hit_q;
  assign bus.ds_idx  = ds_idx_q;
  assign bus.ds_miss = ds_miss_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_srv_addr_hit_v3.sv
// Directed bench for srv_addr_hit_v3: decode, backpressure, runtime config, lock/error, reset.
module tb_srv_addr_hit_v3;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [0:0]  cfg_idx;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_wdata;
  logic        cfg_lock;
  logic        cfg_err;
`ifdef SRV_ADDR_HIT_MULTI_ERR_EN
  logic        ds_multi;
  logic [7:0]  multi_cnt;
`endif

  int assertions = 0;
  int failures   = 0;

  srv_addr_hit_v3_if #(.AW(32), .MAX_REGION(2)) bus ();

  srv_addr_hit_v3 dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_sel   (cfg_sel),
    .cfg_wdata (cfg_wdata),
    .cfg_lock  (cfg_lock),
    .cfg_err   (cfg_err)
`ifdef SRV_ADDR_HIT_MULTI_ERR_EN
    ,
    .ds_multi  (ds_multi),
    .multi_cnt (multi_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents an address for one edge and leaves us_vld high so calls chain back-to-back.
  task automatic applyStimulus(input logic [31:0] addr);
    @(negedge clk);
    bus.us_vld  = 1'b1;
    bus.us_addr = addr;
    @(posedge clk);
    #1;
  endtask

  task automatic goIdle();
    @(negedge clk);
    bus.us_vld = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic cfgWrite(input logic [0:0] idx, input logic [1:0] sel, input logic [31:0] data);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_idx   = idx;
    cfg_sel   = sel;
    cfg_wdata = data;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic checkResult(input string tag, input logic [31:0] addr, input logic [1:0] hit,
                             input logic idx, input logic miss);
    checkOutput({tag, "_vld"},  bus.ds_vld,  1);
    checkOutput({tag, "_addr"}, bus.ds_addr, addr);
    checkOutput({tag, "_hit"},  bus.ds_hit,  hit);
    checkOutput({tag, "_idx"},  bus.ds_idx,  idx);
    checkOutput({tag, "_miss"}, bus.ds_miss, miss);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    bus.us_vld  = 1'b0;
    bus.us_addr = '0;
    bus.ds_rdy  = 1'b0;
    cfg_we      = 1'b0;
    cfg_idx     = '0;
    cfg_sel     = '0;
    cfg_wdata   = '0;
    cfg_lock    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_vld",    bus.ds_vld,  0);
    checkOutput("rst_hit",    bus.ds_hit,  0);
    checkOutput("rst_idx",    bus.ds_idx,  0);
    checkOutput("rst_miss",   bus.ds_miss, 0);
    checkOutput("rst_addr",   bus.ds_addr, 0);
    checkOutput("rst_cfgerr", cfg_err,     0);
    checkOutput("rst_usrdy",  bus.us_rdy,  1);
    @(negedge clk);
    rst        = 1'b0;
    bus.ds_rdy = 1'b1;

    // Basic decode and granularity edges on the reset table
    applyStimulus(32'h5000_1234); checkResult("dec_e0",   32'h5000_1234, 2'b01, 1'b0, 1'b0);
    applyStimulus(32'h7000_0000); checkResult("dec_miss", 32'h7000_0000, 2'b00, 1'b0, 1'b1);
    applyStimulus(32'h6FFF_FFFF); checkResult("gran_top", 32'h6FFF_FFFF, 2'b10, 1'b1, 1'b0);
    applyStimulus(32'h4FFF_F000); checkResult("gran_low", 32'h4FFF_F000, 2'b00, 1'b0, 1'b1);
    applyStimulus(32'h5FFF_F800); checkResult("gran_lsb", 32'h5FFF_F800, 2'b01, 1'b0, 1'b0);
    goIdle();
    checkOutput("idle_vld", bus.ds_vld, 0);

    // Backpressure: first address accepted, then held off for 3 cycles
    bus.ds_rdy = 1'b0;
    applyStimulus(32'h5000_0000);
    checkResult("bp_acc", 32'h5000_0000, 2'b01, 1'b0, 1'b0);
    checkOutput("bp_usrdy", bus.us_rdy, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h6000_0000);
      checkOutput("bp_hold_usrdy", bus.us_rdy,  0);
      checkOutput("bp_hold_vld",   bus.ds_vld,  1);
      checkOutput("bp_hold_addr",  bus.ds_addr, 32'h5000_0000);
      checkOutput("bp_hold_hit",   bus.ds_hit,  2'b01);
    end
    @(negedge clk);
    bus.ds_rdy = 1'b1;
    @(posedge clk);
    #1;
    checkResult("bp_rel",  32'h6000_0000, 2'b10, 1'b1, 1'b0);
    applyStimulus(32'h5000_0004); checkResult("b2b_0", 32'h5000_0004, 2'b01, 1'b0, 1'b0);
    applyStimulus(32'h7000_0000); checkResult("b2b_1", 32'h7000_0000, 2'b00, 1'b0, 1'b1);
    goIdle();

    // Runtime config
    cfgWrite(1'b1, 2'd2, 32'h0);
    applyStimulus(32'h6000_0000); checkResult("cfg_vis0", 32'h6000_0000, 2'b00, 1'b0, 1'b1);
    goIdle();
    cfgWrite(1'b0, 2'd1, 32'h6FFF_FFFF);
    applyStimulus(32'h6000_0000); checkResult("cfg_lim", 32'h6000_0000, 2'b01, 1'b0, 1'b0);
    goIdle();
    @(negedge clk);
    bus.us_vld  = 1'b1;
    bus.us_addr = 32'h6000_0000;
    cfg_we      = 1'b1;
    cfg_idx     = 1'b0;
    cfg_sel     = 2'd1;
    cfg_wdata   = 32'h5FFF_FFFF;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    checkResult("same_old", 32'h6000_0000, 2'b01, 1'b0, 1'b0);
    applyStimulus(32'h6000_0000); checkResult("same_new", 32'h6000_0000, 2'b00, 1'b0, 1'b1);
    goIdle();

`ifdef SRV_ADDR_HIT_MULTI_ERR_EN
    cfgWrite(1'b0, 2'd1, 32'h6FFF_FFFF);
    cfgWrite(1'b1, 2'd2, 32'h1);
    applyStimulus(32'h6000_0000);
    applyStimulus(32'h6000_0000);
    checkOutput("multi_hit", bus.ds_hit, 2'b01);
    checkOutput("multi_flag", ds_multi, 1);
    checkOutput("multi_cnt", multi_cnt, 2);
    goIdle();
`endif

    // Lock with a same-cycle write, then a rejected write
    @(negedge clk);
    cfg_lock  = 1'b1;
    cfg_we    = 1'b1;
    cfg_idx   = 1'b0;
    cfg_sel   = 2'd0;
    cfg_wdata = 32'h5800_0000;
    @(posedge clk);
    #1;
    cfg_lock = 1'b0;
    cfg_we   = 1'b0;
    checkOutput("lock_same_err", cfg_err, 0);
    applyStimulus(32'h5000_0000); checkResult("lock_same_wr", 32'h5000_0000, 2'b00, 1'b0, 1'b1);
    goIdle();
    cfgWrite(1'b0, 2'd0, 32'h0);
    checkOutput("locked_err", cfg_err, 1);
    applyStimulus(32'h4000_0000); checkResult("locked_tbl", 32'h4000_0000, 2'b00, 1'b0, 1'b1);
    goIdle();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("locked_err_sticky", cfg_err, 1);

    // Asynchronous reset drops a stalled result
    bus.ds_rdy = 1'b0;
    applyStimulus(32'h5900_0000);
    checkOutput("pre_rst_vld", bus.ds_vld, 1);
    bus.us_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_vld", bus.ds_vld, 0);
    checkOutput("async_rst_hit", bus.ds_hit, 0);
    checkOutput("async_rst_err", cfg_err,    0);
    @(negedge clk);
    rst        = 1'b0;
    bus.ds_rdy = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("no_replay_vld", bus.ds_vld, 0);
    applyStimulus(32'h5000_1234); checkResult("reload_e0", 32'h5000_1234, 2'b01, 1'b0, 1'b0);
    goIdle();

    // Reserved select is rejected and leaves the table intact
    cfgWrite(1'b0, 2'd3, 32'h0);
    checkOutput("sel3_err", cfg_err, 1);
    applyStimulus(32'h5000_1234); checkResult("sel3_tbl", 32'h5000_1234, 2'b01, 1'b0, 1'b0);
    goIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
